// File: rtl/z3_busmaster_arbiter_pkg.sv
// Shared definitions for the Zorro III bus-master arbiter: state encodings,
// parameter defaults and the counter-width helper.
package z3_busmaster_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQ       = 3'd1,
        ARB_WAIT_FREE = 3'd2,
        ARB_OWN       = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_e;

    localparam int GRANT_TIMEOUT_DEF = 255;
    localparam int MAX_TENURE_DEF    = 64;
    localparam int HOLDOFF_DEF       = 2;

    // One spare bit so the terminal value itself is representable.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/z3_busmaster_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int          WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             CLK,
    input  logic             IORST_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/z3_busmaster_arbiter.sv
// Arbitrates between the NCR SCSI core's bus requests and Zorro III bus
// ownership: request, wait for the bus to go free, own it, then hold off.
module z3_busmaster_arbiter
    import z3_busmaster_arbiter_pkg::*;
#(
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
    parameter int MAX_TENURE    = MAX_TENURE_DEF,
    parameter int HOLDOFF       = HOLDOFF_DEF
) (
    input  logic CLK,
    input  logic IORST_n,
    input  logic SBR,
    output logic SBG,
    output logic BR_n,
    input  logic BG_n,
    input  logic FCS_n,
    input  logic DTACK_n,
    input  logic BERR_n,
    input  logic LOCK,
    input  logic slave_busy,
    output logic MASTER,
    output logic grant_timeout
);

    localparam int WAIT_W = cnt_width(GRANT_TIMEOUT);
    localparam int TEN_W  = cnt_width(MAX_TENURE);

    localparam logic [WAIT_W-1:0] GT_LAST   = WAIT_W'(GRANT_TIMEOUT);
    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(HOLDOFF - 1);
    localparam logic [TEN_W-1:0]  TEN_MAX   = TEN_W'(MAX_TENURE);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              r_run;
    logic              r_br_n;
    logic              r_sbg;
    logic              r_master;
    logic              r_grant_timeout;
    logic              w_timeout;
    logic              w_wait_clr;
    logic              w_ten_clr;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic [TEN_W-1:0]  w_tenure_cnt;

    // The wait counter times both the grant wait in REQ and the holdoff in RELEASE.
    assign w_wait_clr = (w_next_state != r_state) ||
                        !(r_state inside {ARB_REQ, ARB_RELEASE});
    assign w_ten_clr  = (r_state != ARB_OWN);

    sat_counter #(.WIDTH(WAIT_W), .MAX(GRANT_TIMEOUT)) u_wait_cnt (
        .CLK     (CLK),
        .IORST_n (IORST_n),
        .i_clr   (w_wait_clr),
        .i_en    (1'b1),
        .o_count (w_wait_cnt)
    );

    sat_counter #(.WIDTH(TEN_W), .MAX(MAX_TENURE)) u_tenure_cnt (
        .CLK     (CLK),
        .IORST_n (IORST_n),
        .i_clr   (w_ten_clr),
        .i_en    (1'b1),
        .o_count (w_tenure_cnt)
    );

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        w_next_state = r_state;
        w_timeout    = 1'b0;
        if (r_run) begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (SBR && !slave_busy) w_next_state = ARB_REQ;
                end
                ARB_REQ: begin
                    if (!BG_n) begin
                        w_next_state = ARB_WAIT_FREE;
                    end else if (!SBR) begin
                        w_next_state = ARB_RELEASE;
                    end else if (w_wait_cnt == GT_LAST) begin
                        w_next_state = ARB_RELEASE;
                        w_timeout    = 1'b1;
                    end
                end
                ARB_WAIT_FREE: begin
                    if (FCS_n && DTACK_n) w_next_state = ARB_OWN;
                end
                ARB_OWN: begin
                    // A bus error aborts at once; otherwise the cycle in flight must finish.
                    if (!BERR_n) begin
                        w_next_state = ARB_RELEASE;
                    end else if (FCS_n && (!SBR || ((w_tenure_cnt == TEN_MAX) && !LOCK))) begin
                        w_next_state = ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (w_wait_cnt == HOLD_LAST) w_next_state = ARB_IDLE;
                end
                default: w_next_state = ARB_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change together with it.
    // r_run holds the FSM for one edge after reset release.
    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            r_state         <= ARB_IDLE;
            r_run           <= 1'b0;
            r_br_n          <= 1'b1;
            r_sbg           <= 1'b0;
            r_master        <= 1'b0;
            r_grant_timeout <= 1'b0;
        end else begin
            r_run           <= 1'b1;
            r_state         <= w_next_state;
            r_br_n          <= !(w_next_state inside {ARB_REQ, ARB_WAIT_FREE, ARB_OWN});
            r_sbg           <= (w_next_state == ARB_OWN);
            r_master        <= (w_next_state == ARB_OWN);
            r_grant_timeout <= w_timeout;
        end
    end

    assign BR_n          = r_br_n;
    assign SBG           = r_sbg;
    assign MASTER        = r_master;
    assign grant_timeout = r_grant_timeout;

endmodule

// File: tb/tb_z3_busmaster_arbiter.sv
// Directed bench for z3_busmaster_arbiter: a phase/age model checked every
// negedge, plus hand-computed literal expectations at posedge+1.
module tb_z3_busmaster_arbiter;

    localparam int GT = 255;
    localparam int MT = 64;
    localparam int HO = 2;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_WAIT = 2;
    localparam int M_OWN  = 3;
    localparam int M_REL  = 4;

    logic CLK = 1'b0;
    logic IORST_n, SBR, BG_n, FCS_n, DTACK_n, BERR_n, LOCK, slave_busy;
    logic SBG, BR_n, MASTER, grant_timeout;

    int n_vec = 0;
    int n_err = 0;
    int n;

    z3_busmaster_arbiter #(.GRANT_TIMEOUT(GT), .MAX_TENURE(MT), .HOLDOFF(HO)) dut (
        .CLK           (CLK),
        .IORST_n       (IORST_n),
        .SBR           (SBR),
        .SBG           (SBG),
        .BR_n          (BR_n),
        .BG_n          (BG_n),
        .FCS_n         (FCS_n),
        .DTACK_n       (DTACK_n),
        .BERR_n        (BERR_n),
        .LOCK          (LOCK),
        .slave_busy    (slave_busy),
        .MASTER        (MASTER),
        .grant_timeout (grant_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_sbg(input string name);
        int k = 0;
        while (!SBG && k < 30) begin
            step();
            k++;
        end
        check(name, int'(SBG), 1);
    endtask

    // Model: current phase plus how many cycles it has lasted; outputs follow the phase.
    int  m_ph, m_age, m_nxt, m_ten;
    bit  m_run, m_to;
    logic e_br_n, e_sbg, e_master, e_gt;

    always @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            m_ph = M_IDLE; m_age = 0; m_run = 0;
            e_br_n = 1'b1; e_sbg = 1'b0; e_master = 1'b0; e_gt = 1'b0;
        end else if (!m_run) begin
            m_run = 1;
        end else begin
            m_nxt = m_ph;
            m_to  = 0;
            m_ten = (m_age > MT) ? MT : m_age;
            case (m_ph)
                M_IDLE: if (SBR && !slave_busy) m_nxt = M_REQ;
                M_REQ: begin
                    if (!BG_n) m_nxt = M_WAIT;
                    else if (!SBR) m_nxt = M_REL;
                    else if (m_age == GT) begin m_nxt = M_REL; m_to = 1; end
                end
                M_WAIT: if (FCS_n && DTACK_n) m_nxt = M_OWN;
                M_OWN: begin
                    if (!BERR_n) m_nxt = M_REL;
                    else if (FCS_n && (!SBR || (m_ten == MT && !LOCK))) m_nxt = M_REL;
                end
                default: if (m_age == HO - 1) m_nxt = M_IDLE;
            endcase
            m_age    = (m_nxt == m_ph) ? m_age + 1 : 0;
            m_ph     = m_nxt;
            e_br_n   = !(m_ph == M_REQ || m_ph == M_WAIT || m_ph == M_OWN);
            e_sbg    = (m_ph == M_OWN);
            e_master = (m_ph == M_OWN);
            e_gt     = m_to;
        end
    end

    always @(negedge CLK) begin
        check("cyc_br_n",          int'(BR_n),          int'(e_br_n));
        check("cyc_sbg",           int'(SBG),           int'(e_sbg));
        check("cyc_master",        int'(MASTER),        int'(e_master));
        check("cyc_grant_timeout", int'(grant_timeout), int'(e_gt));
    end

    initial begin
        IORST_n = 0; SBR = 0; BG_n = 1; FCS_n = 1; DTACK_n = 1;
        BERR_n = 1; LOCK = 0; slave_busy = 0;
        repeat (3) step();
        check("rst_br_n", int'(BR_n), 1);
        check("rst_sbg", int'(SBG), 0);
        check("rst_master", int'(MASTER), 0);
        check("rst_gt", int'(grant_timeout), 0);
        IORST_n = 1;
        step(); step();

        // Basic grant: BG_n low three cycles after BR_n falls, SBG five cycles after.
        SBR = 1;
        step();
        check("req_br_n_low", int'(BR_n), 0);
        repeat (3) step();
        BG_n = 0;
        n = 0;
        while (!SBG && n < 20) begin step(); n++; end
        check("grant_latency", 3 + n, 5);
        check("own_master", int'(MASTER), 1);
        SBR = 0; BG_n = 1;
        step();
        check("drop_sbg", int'(SBG), 0);
        check("drop_br_n", int'(BR_n), 1);
        check("drop_master", int'(MASTER), 0);
        repeat (3) step();

        // Request withdrawn while waiting for grant: release, no timeout pulse.
        SBR = 1;
        step();
        SBR = 0;
        step();
        check("abandon_br_n", int'(BR_n), 1);
        check("abandon_gt", int'(grant_timeout), 0);
        repeat (3) step();

        // Grant never arrives: BR_n low for 256 cycles, then a single pulse.
        SBR = 1;
        step();
        n = 0;
        while (BR_n == 1'b0 && n < 400) begin n++; step(); end
        check("timeout_req_cycles", n, 256);
        check("timeout_pulse", int'(grant_timeout), 1);
        check("timeout_no_sbg", int'(SBG), 0);
        SBR = 0;
        step();
        check("timeout_pulse_end", int'(grant_timeout), 0);
        repeat (3) step();

        // Granted while the bus is busy: hold in WAIT_FREE until FCS_n and DTACK_n both high.
        SBR = 1; FCS_n = 0;
        step();
        BG_n = 0;
        step();
        repeat (10) step();
        check("busy_bus_no_sbg", int'(SBG), 0);
        check("busy_bus_br_n", int'(BR_n), 0);
        FCS_n = 1; DTACK_n = 0;
        step(); step();
        check("dtack_low_no_sbg", int'(SBG), 0);
        DTACK_n = 1;
        step();
        check("sbg_after_free", int'(SBG), 1);

        // Tenure expired with FCS_n low: no release until the cycle completes.
        FCS_n = 0;
        repeat (80) step();
        check("no_release_fcs_low", int'(SBG), 1);
        FCS_n = 1;
        step();
        check("tenure_release", int'(SBG), 0);

        // Idle bus, unlocked: ownership lasts tenure 0..64 = 65 cycles.
        wait_sbg("reown_unlocked");
        n = 0;
        while (SBG && n < 200) begin n++; step(); end
        check("tenure_cycles", n, 65);

        // Locked: ownership retained past the tenure limit.
        LOCK = 1;
        wait_sbg("reown_locked");
        n = 0;
        repeat (100) begin step(); if (SBG) n++; end
        check("locked_retained", n, 100);

        // Bus error during a cycle in flight aborts ownership next cycle.
        FCS_n = 0; BERR_n = 0;
        step();
        check("berr_sbg", int'(SBG), 0);
        check("berr_master", int'(MASTER), 0);
        BERR_n = 1; FCS_n = 1;

        // Asynchronous reset mid-OWN.
        wait_sbg("reown_for_reset");
        #2 IORST_n = 0;
        #1;
        check("async_rst_br_n", int'(BR_n), 1);
        check("async_rst_sbg", int'(SBG), 0);
        check("async_rst_master", int'(MASTER), 0);
        check("async_rst_gt", int'(grant_timeout), 0);
        slave_busy = 1;
        step();
        IORST_n = 1;
        n = 0;
        repeat (5) begin step(); if (!BR_n) n++; end
        check("busy_blocks_req", n, 0);

        // Reset release: no state change on the first edge, REQ on the second.
        IORST_n = 0;
        #1 slave_busy = 0;
        step();
        IORST_n = 1;
        step();
        check("sync_first_edge", int'(BR_n), 1);
        step();
        check("sync_second_edge", int'(BR_n), 0);

        SBR = 0; BG_n = 1; LOCK = 0;
        repeat (6) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
